muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit with a valid/ready handshake. It executes the eight M-extension operations that the ALU control unit routes away from the single-cycle ALU: opcode `ARITHMETIC` with funct7 = 0000001. The unit produces one result bit per cycle and holds its result until the consumer accepts it. It sits beside the ALU in the EX stage; the pipeline stalls on `busy`.

---
 rtl/muldiv_unit_pkg.sv | 32 +++
 rtl/muldiv_step.sv | 44 ++++
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared encodings for the iterative RV32M multiply/divide unit
package muldiv_unit_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

    // True when an instruction's funct7 routes it to this unit rather than the ALU
    function automatic logic is_muldiv(input logic [6:0] funct7);
        return funct7 == FUNCT7_MULDIV;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add or restoring shift-subtract iteration
module muldiv_step
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  step_mode_e         i_mode,
    input  logic [2*XLEN:0]    i_acc,
    input  logic [XLEN-1:0]    i_operand,
    output logic [2*XLEN:0]    o_acc,
    output logic               o_q_bit
);

    // Multiply: acc = {carry, high partial, remaining multiplier bits}.
    // Divide:   acc = {remainder (XLEN+1), dividend bits being replaced by quotient bits}.
    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_rem_shift;
    logic [XLEN:0] w_diff;

    // Single iteration; the divide quotient bit is returned separately, its slot left zero
    always_comb begin
        w_sum       = i_acc[2*XLEN:XLEN] + {1'b0, i_operand};
        w_rem_shift = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
        w_diff      = w_rem_shift - {1'b0, i_operand};
        o_acc       = '0;
        o_q_bit     = 1'b0;
        if (i_mode == STEP_MUL) begin
            if (i_acc[0]) begin
                o_acc = {1'b0, w_sum, i_acc[XLEN-1:1]};
            end else begin
                o_acc = {1'b0, i_acc[2*XLEN:1]};
            end
        end else begin
            // A set top bit of the difference is the borrow: keep the shifted remainder
            o_q_bit = ~w_diff[XLEN];
            if (o_q_bit) begin
                o_acc = {w_diff, i_acc[XLEN-2:0], 1'b0};
            end else begin
                o_acc = {w_rem_shift, i_acc[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with valid/ready handshakes
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    input  logic            result_ready,
    output logic            busy
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         r_state;
    md_state_e         w_next_state;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN:0]   r_acc;
    logic [XLEN-1:0]   r_operand;
    logic [2:0]        r_funct3;
    logic              r_neg_a;
    logic              r_neg_b;
    logic              r_special;
    logic [XLEN-1:0]   r_result;
    logic              r_result_valid;

    logic              w_accept;
    logic              w_is_div;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_special;
    logic [XLEN-1:0]   w_special_val;
    logic              w_iterating;
    logic              w_finish;
    logic [2*XLEN:0]   w_step_acc;
    logic              w_step_q;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    assign start_ready  = (r_state == MD_IDLE);
    assign busy         = (r_state != MD_IDLE);
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign w_accept     = start_valid && start_ready && !kill;
    assign w_iterating  = (r_state == MD_MUL) || (r_state == MD_DIV);
    assign w_finish     = w_iterating && (r_cnt == '0);

    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_mode    ((r_state == MD_DIV) ? STEP_DIV : STEP_MUL),
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .o_acc     (w_step_acc),
        .o_q_bit   (w_step_q)
    );

    // Request decode: operand signs, magnitudes and the single-cycle special cases
    always_comb begin
        w_is_div      = funct3[2];
        w_neg_a       = op_a[XLEN-1] && (funct3 == FUNCT3_MULH || funct3 == FUNCT3_MULHSU ||
                                         funct3 == FUNCT3_DIV  || funct3 == FUNCT3_REM);
        w_neg_b       = op_b[XLEN-1] && (funct3 == FUNCT3_MULH || funct3 == FUNCT3_DIV ||
                                         funct3 == FUNCT3_REM);
        w_mag_a       = w_neg_a ? (~op_a + 1'b1) : op_a;
        w_mag_b       = w_neg_b ? (~op_b + 1'b1) : op_b;
        w_special     = 1'b0;
        w_special_val = '0;
        if (w_is_div && op_b == '0) begin
            w_special     = 1'b1;
            w_special_val = funct3[1] ? op_a : '1;
        end else if ((funct3 == FUNCT3_DIV || funct3 == FUNCT3_REM) &&
                     op_a == MOST_NEG && op_b == '1) begin
            w_special     = 1'b1;
            w_special_val = funct3[1] ? '0 : op_a;
        end
    end

    // Sign correction and result selection after the last iteration
    always_comb begin
        w_prod  = (r_neg_a ^ r_neg_b) ? (~r_acc[2*XLEN-1:0] + 1'b1) : r_acc[2*XLEN-1:0];
        w_quot  = (r_neg_a ^ r_neg_b) ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
        w_rem   = r_neg_a ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
        w_final = '0;
        if (r_special) begin
            w_final = r_acc[XLEN-1:0];
        end else if (r_funct3 == FUNCT3_MUL) begin
            w_final = w_prod[XLEN-1:0];
        end else if (!r_funct3[2]) begin
            w_final = w_prod[2*XLEN-1:XLEN];
        end else if (!r_funct3[1]) begin
            w_final = w_quot;
        end else begin
            w_final = w_rem;
        end
    end

    // Next-state logic; kill overrides everything, special cases spend one cycle with a zero count
    always_comb begin
        w_next_state = r_state;
        if (kill) begin
            w_next_state = MD_IDLE;
        end else begin
            case (r_state)
                MD_IDLE: if (start_valid) w_next_state = (w_is_div || w_special) ? MD_DIV : MD_MUL;
                MD_MUL,
                MD_DIV:  if (r_cnt == '0) w_next_state = MD_DONE;
                MD_DONE: if (result_ready) w_next_state = MD_IDLE;
                default: w_next_state = MD_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand latch and per-cycle iteration of the accumulator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_funct3  <= '0;
            r_neg_a   <= 1'b0;
            r_neg_b   <= 1'b0;
            r_special <= 1'b0;
        end else if (w_accept) begin
            r_funct3  <= funct3;
            r_neg_a   <= w_neg_a;
            r_neg_b   <= w_neg_b;
            r_special <= w_special;
            r_operand <= w_is_div ? w_mag_b : w_mag_a;
            if (w_special) begin
                r_acc <= {{(XLEN+1){1'b0}}, w_special_val};
                r_cnt <= '0;
            end else begin
                r_acc <= {{(XLEN+1){1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                r_cnt <= CW'(XLEN);
            end
        end else if (w_iterating && r_cnt != '0) begin
            r_acc <= (r_state == MD_DIV) ? {w_step_acc[2*XLEN:1], w_step_q} : w_step_acc;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Registered result and its valid flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else if (kill) begin
            r_result_valid <= 1'b0;
        end else if (w_finish) begin
            r_result       <= w_final;
            r_result_valid <= 1'b1;
        end else if (r_state == MD_DONE && result_ready) begin
            r_result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        kill;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .funct3       (funct3),
        .op_a         (op_a),
        .op_b         (op_b),
        .kill         (kill),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference results from RISC-V M-extension arithmetic on 64-bit integers
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sub;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        p;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        sub = {32'b0, b};
        p   = '0;
        case (f)
            FUNCT3_MUL:    begin p = sa * sb;  return p[31:0];  end
            FUNCT3_MULH:   begin p = sa * sb;  return p[63:32]; end
            FUNCT3_MULHSU: begin p = sa * sub; return p[63:32]; end
            FUNCT3_MULHU:  begin p = ua * ub;  return p[63:32]; end
            FUNCT3_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            FUNCT3_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            FUNCT3_REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default:       begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == FUNCT3_DIV || f == FUNCT3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one request, then count edges from the accept until result_valid (bounded)
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit busy_ok);
        @(negedge clk);
        funct3      = f;
        op_a        = a;
        op_b        = b;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        funct3      = 3'($urandom);
        op_a        = $urandom;
        op_b        = $urandom;
        lat         = 0;
        busy_ok     = 1'b1;
        while (!result_valid && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
        res = result;
    endtask

    task automatic consume();
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
    endtask

    task automatic run_checked(input string name, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int          lat;
        bit          busy_ok;
        issue(f, a, b, res, lat, busy_ok);
        check({name, " result"}, res, exp);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " busy"}, {31'b0, busy_ok}, 32'd1);
        consume();
        check({name, " idle after accept"}, {30'b0, start_ready, result_valid}, 32'd2);
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] held;
        int          lat;
        bit          busy_ok;
        bit          flag;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{FUNCT3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{FUNCT3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{FUNCT3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{FUNCT3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{FUNCT3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{FUNCT3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{FUNCT3_DIVU,   32'd100,        32'd7,         32'd14,        33};
        vecs[7]  = '{FUNCT3_REMU,   32'd100,        32'd7,         32'd2,         33};
        vecs[8]  = '{FUNCT3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{FUNCT3_REM,    32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{FUNCT3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{FUNCT3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{FUNCT3_REMU,   32'd9,          32'd0,         32'd9,         1};

        reset        = 1'b1;
        start_valid  = 1'b0;
        kill         = 1'b0;
        result_ready = 1'b0;
        funct3       = '0;
        op_a         = '0;
        op_b         = '0;
        #2;
        check("reset state", {result, result_valid, busy, start_ready}, {32'd0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_checked($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom);
            ra = pick_operand();
            rb = pick_operand();
            run_checked($sformatf("rand%0d f%0d %h %h", i, rf, ra, rb), rf, ra, rb,
                        model(rf, ra, rb), model_lat(rf, ra, rb));
        end

        // Backpressure: result and start_ready hold while the consumer stalls
        issue(FUNCT3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, held, lat, busy_ok);
        check("bp result", held, model(FUNCT3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0));
        flag = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (result !== held || start_ready !== 1'b0 || result_valid !== 1'b1) flag = 1'b0;
        end
        check("bp hold stable", {31'b0, flag}, 32'd1);
        consume();
        check("bp start_ready after accept", {31'b0, start_ready}, 32'd1);
        run_checked("bp follow-on", FUNCT3_DIVU, 32'd1000, 32'd33, 32'd30, 33);

        // Kill at iteration 5
        issue_start(FUNCT3_DIV, 32'd12345, 32'd67);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill to idle", {29'b0, busy, start_ready, result_valid}, 32'd2);
        flag = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (result_valid) flag = 1'b0;
        end
        check("kill no result", {31'b0, flag}, 32'd1);

        // Kill together with start in IDLE is not accepted
        @(negedge clk);
        funct3      = FUNCT3_DIVU;
        op_a        = 32'd100;
        op_b        = 32'd0;
        start_valid = 1'b1;
        kill        = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        kill        = 1'b0;
        check("kill+start rejected", {30'b0, busy, start_ready}, 32'd1);
        flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (result_valid || busy) flag = 1'b0;
        end
        check("kill+start stays idle", {31'b0, flag}, 32'd1);

        // Kill while holding a result in DONE
        issue(FUNCT3_MUL, 32'd3, 32'd5, res, lat, busy_ok);
        check("done result before kill", res, 32'd15);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill in done", {30'b0, start_ready, result_valid}, 32'd2);

        // Asynchronous reset mid-divide
        issue_start(FUNCT3_DIVU, 32'hDEAD_BEEF, 32'd17);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        check("reset mid-div", {result, result_valid, busy, start_ready}, {32'd0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        reset = 1'b0;
        run_checked("after reset", FUNCT3_REMU, 32'hDEAD_BEEF, 32'd17,
                    model(FUNCT3_REMU, 32'hDEAD_BEEF, 32'd17), 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic issue_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        funct3      = f;
        op_a        = a;
        op_b        = b;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
